// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I decode constants for the ID stage
package riscv_pkg;

   // major opcodes of the supported subset
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // ALUControl encodings seen by the EX stage
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // immediate format selectors
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   // main-decoder to ALU-decoder operation class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/decode_cycle_if.sv
// rtl/decode_cycle_if.sv - IF/ID inputs, WB write port and ID/EX outputs of the decode stage
interface decode_cycle_if #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
);
   // from IF/ID
   logic [XLEN-1:0]    InstrD;
   logic [XLEN-1:0]    PCD;
   logic [XLEN-1:0]    PCPlus4D;
   // writeback port
   logic               RegWriteW;
   logic [RADDR_W-1:0] RDW;
   logic [XLEN-1:0]    ResultW;
   // ID/EX register contents
   logic               RegWriteE;
   logic               ALUSrcE;
   logic               MemWriteE;
   logic               ResultSrcE;
   logic               BranchE;
   logic [2:0]         ALUControlE;
   logic [XLEN-1:0]    RD1E;
   logic [XLEN-1:0]    RD2E;
   logic [XLEN-1:0]    ImmExtE;
   logic [RADDR_W-1:0] RDE;
   logic [RADDR_W-1:0] RS1E;
   logic [RADDR_W-1:0] RS2E;
   logic [XLEN-1:0]    PCE;
   logic [XLEN-1:0]    PCPlus4E;

   modport master (
      output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW,
      input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
             RD1E, RD2E, ImmExtE, RDE, RS1E, RS2E, PCE, PCPlus4E
   );

   modport slave (
      input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW,
      output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
             RD1E, RD2E, ImmExtE, RDE, RS1E, RS2E, PCE, PCPlus4E
   );
endinterface

// File: rtl/decode_cycle_regfile.sv
// rtl/decode_cycle_regfile.sv - 2-read/1-write register file with x0 hardwired and write-through reads
module register_file #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               writeEn,
   input  logic [RADDR_W-1:0] writeAddr,
   input  logic [XLEN-1:0]    writeData,
   input  logic [RADDR_W-1:0] readAddr1,
   input  logic [RADDR_W-1:0] readAddr2,
   output logic [XLEN-1:0]    readData1,
   output logic [XLEN-1:0]    readData2
);

   logic [XLEN-1:0] mem [NREG];
   logic            writeLive;

   // x0 is never stored, so the bypass must also ignore it
   assign writeLive = writeEn && (writeAddr != '0);

   // storage update on the writeback edge, cleared by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (writeLive) begin
         mem[writeAddr] <= writeData;
      end
   end

   // asynchronous reads; an in-flight write wins so ID/EX captures the new value
   always_comb begin
      readData1 = mem[readAddr1];
      readData2 = mem[readAddr2];
      if (readAddr1 == '0)                           readData1 = '0;
      else if (writeLive && writeAddr == readAddr1)  readData1 = writeData;
      if (readAddr2 == '0)                           readData2 = '0;
      else if (writeLive && writeAddr == readAddr2)  readData2 = writeData;
   end

endmodule

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I ID stage with ID/EX register; DECODE_FLUSH_EN adds the FlushE bubble input
module decode_cycle
   import riscv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int RADDR_W = 5
) (
   input  logic clk,
   input  logic rst,
`ifdef DECODE_FLUSH_EN
   input  logic FlushE,
`endif
   decode_cycle_if.slave bus
);

   logic [XLEN-1:0] instr;
   logic [6:0]      op;
   logic [2:0]      funct3;

   logic            regWrite, aluSrc, memWrite, resultSrc, branch;
   logic [1:0]      immSrc, aluOp;
   logic [2:0]      aluControl;
   logic [XLEN-1:0] immExt, rd1, rd2;
   logic            bubble;

   logic               regWriteQ, aluSrcQ, memWriteQ, resultSrcQ, branchQ;
   logic [2:0]         aluControlQ;
   logic [XLEN-1:0]    rd1Q, rd2Q, immExtQ, pcQ, pcPlus4Q;
   logic [RADDR_W-1:0] rdQ, rs1Q, rs2Q;

   assign instr  = bus.InstrD;
   assign op     = instr[6:0];
   assign funct3 = instr[14:12];

`ifdef DECODE_FLUSH_EN
   assign bubble = FlushE;
`else
   assign bubble = 1'b0;
`endif

   // main decoder; unknown opcodes leave every control low and behave as a NOP
   always_comb begin
      regWrite  = 1'b0;
      aluSrc    = 1'b0;
      memWrite  = 1'b0;
      resultSrc = 1'b0;
      branch    = 1'b0;
      immSrc    = IMM_I;
      aluOp     = ALUOP_ADD;
      case (op)
         OP_LW: begin
            regWrite  = 1'b1;
            aluSrc    = 1'b1;
            resultSrc = 1'b1;
         end
         OP_SW: begin
            memWrite = 1'b1;
            aluSrc   = 1'b1;
            immSrc   = IMM_S;
         end
         OP_R: begin
            regWrite = 1'b1;
            aluOp    = ALUOP_FUNCT;
         end
         OP_I: begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
            aluOp    = ALUOP_FUNCT;
         end
         OP_BEQ: begin
            branch = 1'b1;
            immSrc = IMM_B;
            aluOp  = ALUOP_SUB;
         end
         default: ;
      endcase
   end

   // ALU decoder; bit 30 only selects sub for register-register ops, never for addi
   always_comb begin
      aluControl = ALU_ADD;
      case (aluOp)
         ALUOP_SUB: aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  aluControl = (op[5] && instr[30]) ? ALU_SUB : ALU_ADD;
               3'b010:  aluControl = ALU_SLT;
               3'b110:  aluControl = ALU_OR;
               3'b111:  aluControl = ALU_AND;
               default: aluControl = ALU_ADD;
            endcase
         end
         default: aluControl = ALU_ADD;
      endcase
   end

   // immediate extraction and sign extension for the selected format
   always_comb begin
      case (immSrc)
         IMM_S:   immExt = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   immExt = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default: immExt = {{(XLEN-12){instr[31]}}, instr[31:20]};
      endcase
   end

   register_file #(
      .XLEN    (XLEN),
      .NREG    (NREG),
      .RADDR_W (RADDR_W)
   ) regFile (
      .clk       (clk),
      .rst       (rst),
      .writeEn   (bus.RegWriteW),
      .writeAddr (bus.RDW),
      .writeData (bus.ResultW),
      .readAddr1 (instr[19:15]),
      .readAddr2 (instr[24:20]),
      .readData1 (rd1),
      .readData2 (rd2)
   );

   // ID/EX pipeline register; a bubble clears it like reset does
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || bubble) begin
         regWriteQ   <= 1'b0;
         aluSrcQ     <= 1'b0;
         memWriteQ   <= 1'b0;
         resultSrcQ  <= 1'b0;
         branchQ     <= 1'b0;
         aluControlQ <= '0;
         rd1Q        <= '0;
         rd2Q        <= '0;
         immExtQ     <= '0;
         rdQ         <= '0;
         rs1Q        <= '0;
         rs2Q        <= '0;
         pcQ         <= '0;
         pcPlus4Q    <= '0;
      end else begin
         regWriteQ   <= regWrite;
         aluSrcQ     <= aluSrc;
         memWriteQ   <= memWrite;
         resultSrcQ  <= resultSrc;
         branchQ     <= branch;
         aluControlQ <= aluControl;
         rd1Q        <= rd1;
         rd2Q        <= rd2;
         immExtQ     <= immExt;
         rdQ         <= instr[11:7];
         rs1Q        <= instr[19:15];
         rs2Q        <= instr[24:20];
         pcQ         <= bus.PCD;
         pcPlus4Q    <= bus.PCPlus4D;
      end
   end

   // outputs read as zero for as long as reset is held
   assign bus.RegWriteE   = rst & regWriteQ;
   assign bus.ALUSrcE     = rst & aluSrcQ;
   assign bus.MemWriteE   = rst & memWriteQ;
   assign bus.ResultSrcE  = rst & resultSrcQ;
   assign bus.BranchE     = rst & branchQ;
   assign bus.ALUControlE = rst ? aluControlQ : '0;
   assign bus.RD1E        = rst ? rd1Q       : '0;
   assign bus.RD2E        = rst ? rd2Q       : '0;
   assign bus.ImmExtE     = rst ? immExtQ    : '0;
   assign bus.RDE         = rst ? rdQ        : '0;
   assign bus.RS1E        = rst ? rs1Q       : '0;
   assign bus.RS2E        = rst ? rs2Q       : '0;
   assign bus.PCE         = rst ? pcQ        : '0;
   assign bus.PCPlus4E    = rst ? pcPlus4Q   : '0;

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- ID stage of the 5-stage RV32I pipeline; consumes the IF/ID outputs (InstrD, PCD, PCPlus4D) from the fetch stage.
- Decodes the instruction, reads the 32x32 register file, sign-extends the immediate and registers everything into the ID/EX pipeline register.
- Accepts the writeback port from WB.
- Supported subset: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq.

Parameters:
XLEN, 32, datapath width
NREG, 32, number of architectural registers
RADDR_W, 5, register index width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-low reset
InstrD  in  XLEN  instruction from IF/ID
PCD  in  XLEN  PC of InstrD
PCPlus4D  in  XLEN  PC+4 of InstrD
RegWriteW  in  1  WB write enable
RDW  in  RADDR_W  WB destination register
ResultW  in  XLEN  WB write data
RegWriteE  out  1  registered write enable
ALUSrcE  out  1  0=RD2E, 1=ImmExtE
MemWriteE  out  1  store enable
ResultSrcE  out  1  0=ALU result, 1=memory data
BranchE  out  1  beq flag
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RD1E, RD2E  out  XLEN  register operands
ImmExtE  out  XLEN  sign-extended immediate
RDE, RS1E, RS2E  out  RADDR_W  instr[11:7], [19:15], [24:20]
PCE, PCPlus4E  out  XLEN  forwarded PCs

Behaviour:
- Reset:
  - rst low asynchronously clears every ID/EX register and all NREG registers to 0.
  - While rst is low, all outputs are also combinationally forced to 0.
- Latency: 1 cycle. Values decoded from InstrD before rising edge N appear on the *E outputs after edge N.
- Opcode decode:
  - 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=1, ImmSrc=I, ALUOp=00.
  - 0100011 sw: MemWrite=1, ALUSrc=1, ImmSrc=S, ALUOp=00.
  - 0110011 R-type: RegWrite=1, ALUOp=10.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, ImmSrc=I, ALUOp=10.
  - 1100011 beq: Branch=1, ImmSrc=B, ALUOp=01.
  - Any other opcode, including 0x00000000: all controls 0, so it acts as a NOP.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 uses funct3:
    - 000 -> sub only when op[5]=1 and funct7[5]=1; otherwise add.
    - 010 -> slt; 110 -> or; 111 -> and.
    - Any other funct3 -> add.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- Register file:
  - Asynchronous read; write on rising clk when RegWriteW=1 and RDW!=0.
  - x0 always reads 0; writes to x0 are ignored.
  - Same-cycle write/read of the same nonzero register: the read returns ResultW (write-through bypass), so RD1E/RD2E capture the new value.
- rs1/rs2 fields are registered even for formats that do not use them.

Optional Feature:
DECODE_FLUSH_EN
- Defined:
  - Adds input port FlushE (1 bit).
  - FlushE=1 at a rising edge loads a bubble: all control outputs 0, all data/index outputs 0.
  - FlushE has priority over the normal load. Register-file writes still occur.
- Undefined: no port; the ID/EX register loads every cycle.

Decomposition:
- Package riscv_pkg:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ)
  - ALUControl encodings
  - ImmSrc encodings (IMM_I=00, IMM_S=01, IMM_B=10)
  - ALUOp encodings
- One sub-module: register_file. It holds the 32-entry array, async reset, x0 rule and write-through bypass.
- Control, ALU decode and sign-extend stay inline.

Test Plan:
1. Reset: hold rst=0 with InstrD=0x00500093 -> all outputs 0. Release rst, one clock -> RegWriteE=1, ALUSrcE=1, ImmExtE=5, RDE=1, ALUControlE=000.
2. Write-through: RegWriteW=1, RDW=5, ResultW=0xDEADBEEF, same cycle InstrD=0x00528233 (add x4,x5,x5) -> next cycle RD1E=RD2E=0xDEADBEEF.
3. x0: write RDW=0, ResultW=0x1234, then decode add x1,x0,x0 -> RD1E=RD2E=0.
4. Immediate sign: sw 0xFE112E23 -> ImmExtE=0xFFFFFFFC, MemWriteE=1, RegWriteE=0. beq 0xFE000EE3 -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001.
5. sub/slt: InstrD=0x40208033 -> ALUControlE=001. InstrD=0x0020A033 -> ALUControlE=101. Unknown opcode 0x0000007F -> all controls 0.
6. With DECODE_FLUSH_EN: FlushE=1 with a valid lw in InstrD -> next cycle all *E outputs 0. FlushE=0 on the following cycle -> normal decode resumes.
